target_locator: RTL and testbench
=================================

TARGET_LOCATOR -- requirements
Module: target_locator

Interface
REQ-001 Parameter H_RES, default 640, pixels per line.
REQ-002 Parameter V_RES, default 480, lines per frame.
REQ-003 Parameter LOCK_FRAMES, default 3, consecutive hit frames needed to assert locked.
REQ-004 Parameter LOSE_FRAMES, default 4, consecutive miss frames needed to deassert locked.
REQ-005 pclk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-007 frame_done  input  1  one-cycle pulse: detector finished a frame.
REQ-008 found_in  input  1  detector found the target in the finished frame; valid with frame_done.
REQ-009 pos_in  input  20  linear pixel index of the detection; valid with frame_done.
REQ-010 busy  output  1  high while a sample is being processed.
REQ-011 x_out  output  10  filtered column, 0..H_RES-1.
REQ-012 y_out  output  9  filtered row, 0..V_RES-1.
REQ-013 loc_valid  output  1  one-cycle pulse: x_out, y_out, locked and range_err are updated.
REQ-014 locked  output  1  target track established.
REQ-015 range_err  output  1  last sample had pos_in >= H_RES*V_RES; updated with loc_valid.
REQ-016 overrun  output  1  one-cycle pulse: frame_done arrived while busy.

Function
REQ-017 States: IDLE, DIVIDE, UPDATE, PUBLISH; reset state is IDLE.
REQ-018 IDLE: on frame_done=1, register pos_in and found_in, clear the iteration counter, go to DIVIDE, set busy.
REQ-019 DIVIDE: restoring shift-subtract of pos by H_RES, 9 iterations (quotient bits 8 down to 0), one iteration per cycle; quotient gives row and remainder gives column.
REQ-020 The DIVIDE state always runs 9 cycles regardless of found_in, so latency is constant.
REQ-021 UPDATE, one cycle, hit case (found and in range): if the hit streak is 0, load x/y directly; otherwise x_f = (x_f + x_new + 1) >> 1, and likewise for y, using 11-bit/10-bit intermediates with no overflow.
REQ-022 UPDATE, miss case (found=0 or out of range): hold x_out and y_out.
REQ-023 Hit streak and miss streak are saturating counters; a hit clears the miss streak, and a miss clears the hit streak.
REQ-024 locked rises when the hit streak reaches LOCK_FRAMES, and falls when the miss streak reaches LOSE_FRAMES; otherwise it holds.
REQ-025 Out-of-range pos_in (>= H_RES*V_RES) sets range_err=1 and is treated as a miss; an in-range sample sets range_err=0.
REQ-026 PUBLISH: loc_valid=1 for exactly one cycle, busy=0, return to IDLE.
REQ-027 Latency: loc_valid is high on the 11th rising edge after the edge that sampled frame_done.
REQ-028 frame_done while busy: the sample is dropped, overrun pulses on the following cycle, and the current operation is unaffected.
REQ-029 frame_done in the PUBLISH cycle counts as busy and is dropped.
REQ-030 pos_in and found_in are ignored when frame_done=0.

Reset
REQ-031 While reset=0, at a pclk edge: state=IDLE; busy, loc_valid, locked, range_err, overrun=0; x_out=0, y_out=0; both streak counters=0.
REQ-032 Reset asserted mid-DIVIDE or mid-UPDATE aborts the operation, and no loc_valid is produced for that sample.

Structure
REQ-033 H_RES, V_RES, the derived frame size 307200, the state encoding, and the coordinate widths SHALL reside in the shared camera package, alongside the detector constants.
REQ-034 The divider SHALL be a separate sub-module, pos_divider, with start/done handshake; the FSM and filter are top-level.

Verification
REQ-035 Reset, then frame_done with found_in=1, pos_in=0 -> loc_valid 11 cycles later, x_out=0, y_out=0, locked=0.
REQ-036 Three consecutive hits pos_in=307199 -> x_out=639, y_out=479, locked=1 on the third loc_valid.
REQ-037 Hit at pos 1000 (x=360, y=1), then hit at pos 1640 (x=360, y=2) -> x_out=360, y_out=2 (rounded average).
REQ-038 Locked, then 4 frames with found_in=0 -> locked=0 on the 4th loc_valid; x_out and y_out unchanged throughout.
REQ-039 pos_in=307200 with found_in=1 -> range_err=1, treated as a miss; a second frame_done 5 cycles later -> overrun pulse, exactly one loc_valid.
REQ-040 reset=0 during DIVIDE cycle 4 -> all outputs 0 next cycle, and no loc_valid within 20 cycles.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared camera-pipeline package.
// Holds the frame geometry, the detector output format, the target-locator
// state encoding and the coordinate/streak widths used by the locator and
// its divider, plus a small saturating-increment helper.
package camera_pkg;

    // Frame geometry
    localparam int H_RES      = 640;
    localparam int V_RES      = 480;
    localparam int FRAME_SIZE = H_RES * V_RES;   // 307200 pixels

    // Detector output: linear pixel index of the detection
    localparam int DET_POS_W  = 20;

    // Coordinate and arithmetic widths
    localparam int POS_W      = DET_POS_W;
    localparam int X_W        = 10;              // column 0..H_RES-1
    localparam int Y_W        = 9;               // row    0..V_RES-1
    localparam int DIV_ITERS  = Y_W;             // one quotient bit per cycle
    localparam int STREAK_W   = 8;               // hit/miss streak counters

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVIDE  = 2'd1,
        ST_UPDATE  = 2'd2,
        ST_PUBLISH = 2'd3
    } loc_state_e;

    // Captured detector sample attributes carried through the division
    typedef struct packed {
        logic found;   // detector reported a target
        logic oor;     // pos_in was outside the frame
    } sample_t;

    function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
        logic [STREAK_W-1:0] r;
        r = (v == {STREAK_W{1'b1}}) ? v : v + 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pos_divider.sv
// pos_divider: sequential restoring divider, linear pixel index -> row/col.
// A start pulse loads the dividend; DIV_ITERS cycles later the quotient
// (row) and remainder (column) are in the output registers.
// Ports:
//   pclk, rst_n  clock / synchronous active-low reset
//   start        load dividend and begin (ignored result of any run in flight)
//   dividend     linear pixel index, sampled with start
//   done         high during the cycle whose edge performs the last
//                iteration; quotient/remainder are final the cycle after
//   quotient     row    (DIV_ITERS bits)
//   remainder    column (X_W bits)
module pos_divider #(
    parameter int DIVISOR = camera_pkg::H_RES
) (
    input  logic                           pclk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [camera_pkg::POS_W-1:0]   dividend,
    output logic                           done,
    output logic [camera_pkg::DIV_ITERS-1:0] quotient,
    output logic [camera_pkg::X_W-1:0]     remainder
);
    import camera_pkg::*;

    localparam int CNT_W = $clog2(DIV_ITERS);
    // Divisor aligned to the top quotient bit; shifted right each iteration
    // instead of using a variable shifter.
    localparam logic [POS_W-1:0] DIV_TOP = POS_W'(DIVISOR << (DIV_ITERS - 1));
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DIV_ITERS - 1);

    logic                 run_q, run_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [POS_W-1:0]     rem_q, rem_d;
    logic [POS_W-1:0]     dsr_q, dsr_d;
    logic [DIV_ITERS-1:0] quo_q, quo_d;
    logic                 qbit;

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        dsr_d = dsr_q;
        quo_d = quo_q;
        qbit  = 1'b0;
        if (start) begin
            run_d = 1'b1;
            cnt_d = '0;
            rem_d = dividend;
            dsr_d = DIV_TOP;
            quo_d = '0;
        end else if (run_q) begin
            if (rem_q >= dsr_q) begin
                rem_d = rem_q - dsr_q;
                qbit  = 1'b1;
            end
            quo_d = {quo_q[DIV_ITERS-2:0], qbit};
            dsr_d = dsr_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            quo_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
            quo_q <= quo_d;
        end
    end

    assign done      = run_q && (cnt_q == LAST);
    assign quotient  = quo_q;
    // For in-frame indices the remainder is below DIVISOR, so the upper bits
    // are zero; out-of-frame results are discarded by the caller.
    assign remainder = rem_q[X_W-1:0];

endmodule

// File: rtl/target_locator.sv
// target_locator: converts per-frame detector hits (linear pixel index) into
// a filtered (x, y) track with lock/lose hysteresis.
// Each accepted frame_done takes constant latency: 1 capture cycle, 9 divide
// cycles, 1 filter-update cycle, then a one-cycle loc_valid publish.
// Ports:
//   pclk, reset          clock / synchronous active-low reset
//   frame_done           detector frame-complete pulse (qualifies found_in/pos_in)
//   found_in, pos_in     detector result for that frame
//   busy                 sample in flight
//   x_out, y_out         filtered column / row
//   loc_valid            one-cycle pulse: x/y/locked/range_err just updated
//   locked               track established
//   range_err            last sample index was outside the frame
//   overrun              one-cycle pulse: frame_done dropped because busy
module target_locator #(
    parameter int H_RES       = camera_pkg::H_RES,
    parameter int V_RES       = camera_pkg::V_RES,
    parameter int LOCK_FRAMES = 3,
    parameter int LOSE_FRAMES = 4
) (
    input  logic                         pclk,
    input  logic                         reset,
    input  logic                         frame_done,
    input  logic                         found_in,
    input  logic [camera_pkg::POS_W-1:0] pos_in,
    output logic                         busy,
    output logic [camera_pkg::X_W-1:0]   x_out,
    output logic [camera_pkg::Y_W-1:0]   y_out,
    output logic                         loc_valid,
    output logic                         locked,
    output logic                         range_err,
    output logic                         overrun
);
    import camera_pkg::*;

    localparam logic [POS_W:0]    FRAME_PIX = (POS_W + 1)'(H_RES * V_RES);
    localparam logic [STREAK_W-1:0] LOCK_N  = STREAK_W'(LOCK_FRAMES);
    localparam logic [STREAK_W-1:0] LOSE_N  = STREAK_W'(LOSE_FRAMES);

    loc_state_e            state_q, state_d;
    sample_t               smp_q, smp_d;
    logic [X_W-1:0]        x_q, x_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic [STREAK_W-1:0]   hit_q, hit_d;
    logic [STREAK_W-1:0]   miss_q, miss_d;
    logic                  locked_q, locked_d;
    logic                  range_err_q, range_err_d;
    logic                  overrun_q, overrun_d;

    logic                  div_start;
    logic                  div_done;
    logic [DIV_ITERS-1:0]  div_quo;
    logic [X_W-1:0]        div_rem;
    logic                  is_hit;

    pos_divider #(
        .DIVISOR (H_RES)
    ) u_div (
        .pclk      (pclk),
        .rst_n     (reset),
        .start     (div_start),
        .dividend  (pos_in),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign is_hit = smp_q.found && !smp_q.oor;

    always_comb begin
        state_d     = state_q;
        smp_d       = smp_q;
        x_d         = x_q;
        y_d         = y_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        locked_d    = locked_q;
        range_err_d = range_err_q;
        div_start   = 1'b0;
        // Any frame_done outside IDLE (including PUBLISH) is dropped.
        overrun_d   = frame_done && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (frame_done) begin
                    smp_d.found = found_in;
                    smp_d.oor   = ({1'b0, pos_in} >= FRAME_PIX);
                    div_start   = 1'b1;
                    state_d     = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                // Divider always runs its full iteration count, so latency
                // does not depend on found/range.
                if (div_done) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                range_err_d = smp_q.oor;
                if (is_hit) begin
                    miss_d = '0;
                    hit_d  = sat_inc(hit_q);
                    if (hit_q == '0) begin
                        x_d = div_rem;
                        y_d = div_quo;
                    end else begin
                        // Rounded average; one extra bit keeps the sum exact.
                        x_d = X_W'(({1'b0, x_q} + {1'b0, div_rem} + (X_W + 1)'(1)) >> 1);
                        y_d = Y_W'(({1'b0, y_q} + {1'b0, div_quo} + (Y_W + 1)'(1)) >> 1);
                    end
                    if (hit_d >= LOCK_N) begin
                        locked_d = 1'b1;
                    end
                end else begin
                    hit_d  = '0;
                    miss_d = sat_inc(miss_q);
                    if (miss_d >= LOSE_N) begin
                        locked_d = 1'b0;
                    end
                end
                state_d = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            smp_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            range_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            smp_q       <= smp_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            range_err_q <= range_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign loc_valid = (state_q == ST_PUBLISH);
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign locked    = locked_q;
    assign range_err = range_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_target_locator.sv
module tb_target_locator;

    logic        pclk = 1'b0;
    logic        reset;
    logic        frame_done;
    logic        found_in;
    logic [19:0] pos_in;
    logic        busy;
    logic [9:0]  x_out;
    logic [8:0]  y_out;
    logic        loc_valid;
    logic        locked;
    logic        range_err;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    target_locator dut (
        .pclk       (pclk),
        .reset      (reset),
        .frame_done (frame_done),
        .found_in   (found_in),
        .pos_in     (pos_in),
        .busy       (busy),
        .x_out      (x_out),
        .y_out      (y_out),
        .loc_valid  (loc_valid),
        .locked     (locked),
        .range_err  (range_err),
        .overrun    (overrun)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        found;
        logic [19:0] pos;
        int          ex;
        int          ey;
        logic        el;
        logic        er;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".busy"},      int'(busy),      0);
        chk({nm, ".loc_valid"}, int'(loc_valid), 0);
        chk({nm, ".locked"},    int'(locked),    0);
        chk({nm, ".range_err"}, int'(range_err), 0);
        chk({nm, ".overrun"},   int'(overrun),   0);
        chk({nm, ".x"},         int'(x_out),     0);
        chk({nm, ".y"},         int'(y_out),     0);
    endtask

    // Drive one frame and check latency and the published result.
    task automatic do_frame(input string nm, input logic f, input logic [19:0] p,
                            input int ex, input int ey, input logic el, input logic er);
        int lat;
        int sx, sy, sl, sr;
        lat = 0; sx = -1; sy = -1; sl = -1; sr = -1;
        @(negedge pclk);
        frame_done = 1'b1; found_in = f; pos_in = p;
        @(posedge pclk); #1;
        frame_done = 1'b0;
        found_in   = 1'($urandom);      // must be ignored without frame_done
        pos_in     = 20'($urandom);
        chk({nm, ".busy"}, int'(busy), 1);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge pclk); #1;
            if (loc_valid) begin
                lat = k;
                sx = int'(x_out); sy = int'(y_out);
                sl = int'(locked); sr = int'(range_err);
            end
        end
        chk({nm, ".latency"},   lat, 10);
        chk({nm, ".x"},         sx,  ex);
        chk({nm, ".y"},         sy,  ey);
        chk({nm, ".locked"},    sl,  int'(el));
        chk({nm, ".range_err"}, sr,  int'(er));
        @(posedge pclk); #1;
        chk({nm, ".after"}, int'({busy, loc_valid}), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int nvalid, lat, sr, sx, sy, sl;

        //            found  pos      x    y   lock  rerr
        vecs[0]  = '{1'b1, 20'd0,      0,   0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 20'd5,      0,   0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 20'd307199, 639, 479, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 20'd307199, 639, 479, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 20'd307199, 639, 479, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 20'd1000,   500, 240, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 20'd1000,   500, 240, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 20'd7,      500, 240, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 20'd9,      500, 240, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 20'd11,     500, 240, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 20'd1000,   360, 1,   1'b0, 1'b0};
        vecs[11] = '{1'b1, 20'd1640,   360, 2,   1'b0, 1'b0};
        vecs[12] = '{1'b1, 20'd307200, 360, 2,   1'b0, 1'b1};
        vecs[13] = '{1'b1, 20'd1,      1,   0,   1'b0, 1'b0};
        vecs[14] = '{1'b1, 20'd643,    2,   1,   1'b0, 1'b0};

        reset = 1'b0; frame_done = 1'b0; found_in = 1'b0; pos_in = '0;
        repeat (3) @(posedge pclk);
        #1;
        chk_all_zero("reset");
        @(negedge pclk);
        reset = 1'b1;
        repeat (2) @(posedge pclk);

        for (int i = 0; i < 15; i++) begin
            do_frame($sformatf("vec%0d", i), vecs[i].found, vecs[i].pos,
                     vecs[i].ex, vecs[i].ey, vecs[i].el, vecs[i].er);
        end

        // Out-of-range sample, then a second frame_done 5 cycles later.
        @(negedge pclk);
        frame_done = 1'b1; found_in = 1'b1; pos_in = 20'd307200;
        @(posedge pclk); #1;
        frame_done = 1'b0;
        repeat (4) @(posedge pclk);
        @(negedge pclk);
        frame_done = 1'b1; found_in = 1'b1; pos_in = 20'd0;
        @(posedge pclk); #1;
        frame_done = 1'b0;
        chk("ovr.pulse", int'(overrun), 1);
        nvalid = 0; lat = 0; sr = -1; sx = -1; sy = -1; sl = -1;
        for (int k = 6; k <= 25; k++) begin
            @(posedge pclk); #1;
            if (k == 6) chk("ovr.pulse_end", int'(overrun), 0);
            if (loc_valid) begin
                nvalid++; lat = k;
                sr = int'(range_err); sx = int'(x_out); sy = int'(y_out); sl = int'(locked);
            end
        end
        chk("ovr.nvalid",    nvalid, 1);
        chk("ovr.latency",   lat,    10);
        chk("ovr.range_err", sr,     1);
        chk("ovr.x_hold",    sx,     2);
        chk("ovr.y_hold",    sy,     1);
        chk("ovr.locked",    sl,     0);

        // Build a locked track so the mid-divide reset has state to clear.
        do_frame("relock0", 1'b1, 20'd307199, 639, 479, 1'b0, 1'b0);
        do_frame("relock1", 1'b1, 20'd307199, 639, 479, 1'b0, 1'b0);
        do_frame("relock2", 1'b1, 20'd307199, 639, 479, 1'b1, 1'b0);

        // Reset during DIVIDE cycle 4.
        @(negedge pclk);
        frame_done = 1'b1; found_in = 1'b1; pos_in = 20'd5;
        @(posedge pclk); #1;
        frame_done = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        reset = 1'b0;
        @(posedge pclk); #1;
        chk_all_zero("midrst");
        @(negedge pclk);
        reset = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge pclk); #1;
            if (loc_valid) nvalid++;
        end
        chk("midrst.no_valid", nvalid, 0);

        // Streaks were cleared: the first hit loads directly, no lock.
        do_frame("postrst", 1'b1, 20'd643, 3, 1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
